frame_writer_pk: RTL and testbench

Parametrised video-packet-to-FIFO writer. It takes an Avalon-ST video stream (sop/eop/valid/ready), skips non-video packets, and captures one video frame per `start`, or every frame in continuous mode. Each pixel is zero-padded to a 32-bit slot, and PIX_PER_WORD slots are packed into one FIFO word. At frame end it reports pixel count and a length/truncation error. It sits between the video pipeline output and the frame-buffer write FIFO that feeds the memory master.

---
 rtl/frame_writer_pk.sv | 168 ++++++++++++++++
 tb/tb_frame_writer_pk.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer_pk.sv
// Video-packet-to-FIFO writer: captures one frame per start (or every frame in cont mode),
// zero-pads pixels to 32-bit slots, packs PIX_PER_WORD slots per word, reports count/error at frame end.
`timescale 1ns/1ps
module frame_writer_pk #(
  parameter int PIX_WIDTH       = 24,
  parameter int PIX_PER_WORD    = 1,
  parameter int DATA_WIDTH      = 32*PIX_PER_WORD,
  parameter int FIFO_DEPTH      = 256,
  parameter int FIFO_DEPTH_LOG2 = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIX_WIDTH-1:0]       din_data,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic                       din_sop,
  input  logic                       din_eop,
  output logic [DATA_WIDTH-1:0]      data_fifo_out,
  output logic                       data_valid_fifo_out,
  input  logic [FIFO_DEPTH_LOG2:0]   usedw_fifo_out,
  input  logic                       start,
  input  logic                       cont,
  input  logic [23:0]                expected_pixels,
  output logic                       endf,
  output logic [23:0]                frame_pixels,
  output logic                       frame_err
);

  localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [23:0]              CNT_MAX     = 24'hFF_FFFF;
  localparam logic [FIFO_DEPTH_LOG2:0] READY_LIMIT = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH - 2);

  logic [1:0]            state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [23:0]           pix_cnt_q, pix_cnt_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  endf_q, endf_d;
  logic [23:0]           frame_pixels_q, frame_pixels_d;
  logic                  frame_err_q, frame_err_d;

  logic                  accept;
  logic [31:0]           pix32;
  logic                  video_hdr;
  logic                  last_slot;
  logic [DATA_WIDTH-1:0] word_new;
  logic                  finish;
  logic                  truncated;

  // One slot of FIFO margin absorbs the write that is still in the output register.
  assign din_ready = usedw_fifo_out < READY_LIMIT;
  assign accept    = din_valid & din_ready;
  assign pix32     = 32'(din_data);
  assign video_hdr = din_sop & (pix32[3:0] == 4'd0);
  assign last_slot = slot_q == SLOT_W'(PIX_PER_WORD - 1);

  always_comb begin
    word_new = word_q;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (slot_q == SLOT_W'(i)) word_new[i*32 +: 32] = pix32;
    end
  end

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    word_d         = word_q;
    pix_cnt_d      = pix_cnt_q;
    wr_d           = 1'b0;
    dout_d         = dout_q;
    endf_d         = 1'b0;
    frame_pixels_d = frame_pixels_q;
    frame_err_d    = frame_err_q;
    finish         = 1'b0;
    truncated      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (accept && video_hdr) begin
          state_d   = ST_CAPTURE;
          slot_d    = '0;
          word_d    = '0;
          pix_cnt_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          if (din_sop) begin
            // New packet interrupts the frame: flush what we have, drop the sop beat.
            if (slot_q != '0) begin
              wr_d   = 1'b1;
              dout_d = word_q;
            end
            word_d    = '0;
            slot_d    = '0;
            truncated = 1'b1;
            finish    = 1'b1;
          end else begin
            pix_cnt_d = (pix_cnt_q == CNT_MAX) ? pix_cnt_q : pix_cnt_q + 24'd1;
            if (last_slot || din_eop) begin
              wr_d   = 1'b1;
              dout_d = word_new;
              word_d = '0;
              slot_d = '0;
            end else begin
              word_d = word_new;
              slot_d = slot_q + SLOT_W'(1);
            end
            finish = din_eop;
          end
        end
      end
      ST_DONE: begin
        state_d = (start || cont) ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d        = ST_DONE;
      endf_d         = 1'b1;
      frame_pixels_d = pix_cnt_d;
      frame_err_d    = truncated ||
                       ((expected_pixels != 24'd0) && (pix_cnt_d != expected_pixels));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      slot_q         <= '0;
      word_q         <= '0;
      pix_cnt_q      <= '0;
      wr_q           <= 1'b0;
      dout_q         <= '0;
      endf_q         <= 1'b0;
      frame_pixels_q <= '0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      word_q         <= word_d;
      pix_cnt_q      <= pix_cnt_d;
      wr_q           <= wr_d;
      dout_q         <= dout_d;
      endf_q         <= endf_d;
      frame_pixels_q <= frame_pixels_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign data_fifo_out       = dout_q;
  assign data_valid_fifo_out = wr_q;
  assign endf                = endf_q;
  assign frame_pixels        = frame_pixels_q;
  assign frame_err           = frame_err_q;

endmodule

// File: tb/tb_frame_writer_pk.sv
// Bench for frame_writer_pk: two instances (1 and 2 pixels per word) share one stream,
// each checked every cycle against a frame-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_frame_writer_pk;

  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAPTURE = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] din_data = '0;
  logic        din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [4:0]  usedw = '0;
  logic        start = 1'b0, cont = 1'b0;
  logic [23:0] expected_pixels = '0;
  logic        rand_bp = 1'b0;

  logic        rdy1, rdy2, dv1, dv2, endf1, endf2, fe1, fe2;
  logic [31:0] dat1;
  logic [63:0] dat2;
  logic [23:0] fp1, fp2;

  int n_checks = 0;
  int n_fail = 0;
  int endf_cnt1 = 0, endf_cnt2 = 0;
  logic [31:0] log1[$];
  logic [63:0] log2[$];

  // reference model state
  int          mode[2] = '{M_IDLE, M_IDLE};
  logic [31:0] pend[2][8];
  int          pend_n[2] = '{0, 0};
  logic [23:0] cnt[2] = '{24'd0, 24'd0};
  logic        exp_wr[2] = '{1'b0, 1'b0};
  logic [63:0] exp_dat[2] = '{64'd0, 64'd0};
  logic        exp_endf[2] = '{1'b0, 1'b0};
  logic [23:0] exp_fp[2] = '{24'd0, 24'd0};
  logic        exp_fe[2] = '{1'b0, 1'b0};

  frame_writer_pk #(.PIX_WIDTH(24), .PIX_PER_WORD(1), .FIFO_DEPTH(DEPTH), .FIFO_DEPTH_LOG2(4)) u_dut1 (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(rdy1),
    .din_sop(din_sop), .din_eop(din_eop), .data_fifo_out(dat1), .data_valid_fifo_out(dv1),
    .usedw_fifo_out(usedw), .start(start), .cont(cont), .expected_pixels(expected_pixels),
    .endf(endf1), .frame_pixels(fp1), .frame_err(fe1));

  frame_writer_pk #(.PIX_WIDTH(24), .PIX_PER_WORD(2), .FIFO_DEPTH(DEPTH), .FIFO_DEPTH_LOG2(4)) u_dut2 (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(rdy2),
    .din_sop(din_sop), .din_eop(din_eop), .data_fifo_out(dat2), .data_valid_fifo_out(dv2),
    .usedw_fifo_out(usedw), .start(start), .cont(cont), .expected_pixels(expected_pixels),
    .endf(endf2), .frame_pixels(fp2), .frame_err(fe2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void emit(int k);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < pend_n[k]; i++) w = w | (64'(pend[k][i]) << (32 * i));
    exp_wr[k]  = 1'b1;
    exp_dat[k] = w;
    pend_n[k]  = 0;
  endfunction

  function automatic void finish_frame(int k, logic tr);
    exp_endf[k] = 1'b1;
    exp_fp[k]   = cnt[k];
    exp_fe[k]   = tr || ((expected_pixels != 0) && (cnt[k] != expected_pixels));
    mode[k]     = M_DONE;
  endfunction

  // Frame-level model: pixels collect in a pending list, a word leaves when the list
  // holds ppw pixels or the frame ends; outputs apply to the cycle after the edge.
  task automatic model_step();
    logic acc;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mode[k] = M_IDLE; pend_n[k] = 0; cnt[k] = '0;
        exp_wr[k] = 1'b0; exp_dat[k] = '0; exp_endf[k] = 1'b0; exp_fp[k] = '0; exp_fe[k] = 1'b0;
      end
      return;
    end
    acc = din_valid && (int'(usedw) < DEPTH - 2);
    for (int k = 0; k < 2; k++) begin
      exp_wr[k] = 1'b0;
      exp_endf[k] = 1'b0;
      case (mode[k])
        M_IDLE: if (start) mode[k] = M_ARMED;
        M_ARMED: if (acc && din_sop && din_data[3:0] == 4'd0) begin
          mode[k] = M_CAPTURE; cnt[k] = '0; pend_n[k] = 0;
        end
        M_CAPTURE: if (acc) begin
          if (din_sop) begin
            if (pend_n[k] > 0) emit(k);
            finish_frame(k, 1'b1);
          end else begin
            pend[k][pend_n[k]] = 32'(din_data);
            pend_n[k]++;
            if (cnt[k] != 24'hFFFFFF) cnt[k] = cnt[k] + 1;
            if (pend_n[k] == k + 1 || din_eop) emit(k);
            if (din_eop) finish_frame(k, 1'b0);
          end
        end
        default: mode[k] = (start || cont) ? M_ARMED : M_IDLE;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // per-cycle compare, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("ready1", 64'(rdy1), 64'(int'(usedw) < DEPTH - 2));
    chk("ready2", 64'(rdy2), 64'(int'(usedw) < DEPTH - 2));
    for (int k = 0; k < 2; k++) begin
      logic        a_dv, a_endf, a_fe;
      logic [63:0] a_dat;
      logic [23:0] a_fp;
      a_dv   = (k == 0) ? dv1 : dv2;
      a_dat  = (k == 0) ? 64'(dat1) : dat2;
      a_endf = (k == 0) ? endf1 : endf2;
      a_fp   = (k == 0) ? fp1 : fp2;
      a_fe   = (k == 0) ? fe1 : fe2;
      chk($sformatf("wr_vld%0d", k + 1), 64'(a_dv), 64'(exp_wr[k]));
      if (exp_wr[k]) chk($sformatf("wr_dat%0d", k + 1), a_dat, exp_dat[k]);
      chk($sformatf("endf%0d", k + 1), 64'(a_endf), 64'(exp_endf[k]));
      chk($sformatf("frame_pixels%0d", k + 1), 64'(a_fp), 64'(exp_fp[k]));
      chk($sformatf("frame_err%0d", k + 1), 64'(a_fe), 64'(exp_fe[k]));
    end
    if (dv1) log1.push_back(dat1);
    if (dv2) log2.push_back(dat2);
    if (endf1) endf_cnt1++;
    if (endf2) endf_cnt2++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) usedw = 5'($urandom_range(10, 15));
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [23:0] d, input logic s, input logic e);
    int n;
    din_data = d; din_sop = s; din_eop = e; din_valid = 1'b1;
    n = 0;
    @(posedge clk);
    while (!rdy1 && n < 1000) begin
      n++;
      @(posedge clk);
    end
    chk("send_timeout", 64'(n >= 1000), 64'd0);
    #1;
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic clear_logs();
    log1.delete();
    log2.delete();
    endf_cnt1 = 0;
    endf_cnt2 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_wr_vld", 64'(dv1), 64'd0);
    chk("rst_dat", 64'(dat2), 64'd0);
    chk("rst_endf", 64'(endf1), 64'd0);
    chk("rst_fp", 64'(fp1), 64'd0);
    chk("rst_fe", 64'(fe2), 64'd0);
    rst = 1'b0;
    idle(2);

    // 4-pixel frame
    clear_logs();
    expected_pixels = 24'd4;
    pulse_start();
    send(24'h000000, 1, 0);
    send(24'h112233, 0, 0);
    send(24'h223344, 0, 0);
    send(24'h334455, 0, 0);
    send(24'h445566, 0, 1);
    idle(3);
    chk("t1_nwr1", 64'(log1.size()), 64'd4);
    if (log1.size() == 4) begin
      chk("t1_w0", 64'(log1[0]), 64'h00112233);
      chk("t1_w3", 64'(log1[3]), 64'h00445566);
    end
    chk("t1_nwr2", 64'(log2.size()), 64'd2);
    if (log2.size() == 2) begin
      chk("t1_pk0", log2[0], 64'h00223344_00112233);
      chk("t1_pk1", log2[1], 64'h00445566_00334455);
    end
    chk("t1_endf", 64'(endf_cnt1), 64'd1);
    chk("t1_fp", 64'(fp1), 64'd4);
    chk("t1_fe", 64'(fe1), 64'd0);

    // control packet while armed, then 5-pixel frame
    clear_logs();
    expected_pixels = 24'd5;
    pulse_start();
    send(24'h00000F, 1, 0);
    send(24'h123456, 0, 0);
    send(24'h654321, 0, 1);
    send(24'h000010, 1, 0);
    for (int i = 1; i <= 5; i++) send(24'hA00000 + 24'(i), 0, i == 5);
    idle(3);
    chk("t2_nwr1", 64'(log1.size()), 64'd5);
    chk("t2_nwr2", 64'(log2.size()), 64'd3);
    if (log2.size() == 3) chk("t2_last", log2[2], 64'h00000000_00A00005);
    chk("t2_fp", 64'(fp2), 64'd5);
    chk("t2_fe", 64'(fe2), 64'd0);

    // truncation after 3 of 4 pixels; trailing beats ignored in IDLE
    clear_logs();
    expected_pixels = 24'd4;
    pulse_start();
    send(24'h000000, 1, 0);
    for (int i = 1; i <= 3; i++) send(24'hB00000 + 24'(i), 0, 0);
    send(24'h000000, 1, 0);
    send(24'hC00001, 0, 0);
    send(24'hC00002, 0, 1);
    idle(3);
    chk("t3_nwr1", 64'(log1.size()), 64'd3);
    chk("t3_nwr2", 64'(log2.size()), 64'd2);
    if (log2.size() == 2) chk("t3_flush", log2[1], 64'h00000000_00B00003);
    chk("t3_fp", 64'(fp1), 64'd3);
    chk("t3_fe", 64'(fe1), 64'd1);
    chk("t3_endf", 64'(endf_cnt2), 64'd1);

    // backpressure stall, continuous mode with two frames
    clear_logs();
    expected_pixels = 24'd0;
    cont = 1'b1;
    pulse_start();
    send(24'h000000, 1, 0);
    usedw = 5'(DEPTH - 2);
    #1;
    chk("bp_not_ready", 64'(rdy1), 64'd0);
    din_data = 24'hD00001; din_valid = 1'b1;
    idle(3);
    usedw = 5'(DEPTH - 3);
    #1;
    chk("bp_ready", 64'(rdy1), 64'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    send(24'hD00002, 0, 1);
    idle(1);
    cont = 1'b0;
    send(24'h000000, 1, 0);
    send(24'hE00001, 0, 0);
    send(24'hE00002, 0, 1);
    idle(3);
    chk("t4_endf", 64'(endf_cnt1), 64'd2);
    chk("t4_nwr1", 64'(log1.size()), 64'd4);
    if (log1.size() == 4) chk("t4_stalled", 64'(log1[0]), 64'h00D00001);
    chk("t4_fp", 64'(fp2), 64'd2);

    // reset mid-capture
    clear_logs();
    pulse_start();
    send(24'h000000, 1, 0);
    send(24'hF00001, 0, 0);
    send(24'hF00002, 0, 0);
    rst = 1'b1;
    #1;
    chk("mrst_fp", 64'(fp1), 64'd0);
    chk("mrst_wr", 64'(dv2), 64'd0);
    chk("mrst_dat", 64'(dat1), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expected_pixels = 24'd3;
    pulse_start();
    send(24'h000000, 1, 0);
    for (int i = 1; i <= 3; i++) send(24'h900000 + 24'(i), 0, i == 3);
    idle(3);
    chk("t5_endf", 64'(endf_cnt1), 64'd1);
    chk("t5_fp", 64'(fp1), 64'd3);
    chk("t5_fe", 64'(fe1), 64'd0);

    // randomized frames, checked by the model every cycle
    rand_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int n;
      int tr_at;
      n = $urandom_range(1, 9);
      tr_at = ($urandom_range(0, 5) == 0 && n > 1) ? $urandom_range(1, n - 1) : -1;
      case ($urandom_range(0, 2))
        0: expected_pixels = '0;
        1: expected_pixels = 24'(n);
        default: expected_pixels = 24'(n + 1);
      endcase
      cont = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) pulse_start();
      if ($urandom_range(0, 2) == 0) begin
        send({20'($urandom), 4'($urandom_range(1, 15))}, 1, 0);
        send(24'($urandom), 0, 0);
        send(24'($urandom), 0, 1);
      end
      send({20'($urandom), 4'd0}, 1, 0);
      for (int i = 0; i < n; i++) begin
        if (i == tr_at) begin
          send(24'($urandom), 1, 0);
          break;
        end
        send(24'($urandom), 0, i == n - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle($urandom_range(0, 3));
    end
    rand_bp = 1'b0;
    usedw = '0;
    cont = 1'b0;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
